// File: rtl/circular_dma_stream_arbiter.sv
// Packet-level round-robin arbiter merging several AXI-Stream sources into one
// S2MM stream; a grant is held until the granted source's tlast beat.
module circular_dma_stream_arbiter #(
  parameter int unsigned C_NUM_SOURCES = 4,
  parameter int unsigned C_AXIS_WIDTH  = 64,
  parameter int unsigned C_ID_WIDTH    = (C_NUM_SOURCES > 1) ? $clog2(C_NUM_SOURCES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    enable,
  input  logic                                    clear_counters,
  output logic                                    busy,
  output logic [C_ID_WIDTH-1:0]                   grant_idx,
  output logic [32*C_NUM_SOURCES-1:0]             pkt_count,
  input  logic [C_AXIS_WIDTH*C_NUM_SOURCES-1:0]   s_axis_tdata,
  input  logic [C_NUM_SOURCES-1:0]                s_axis_tlast,
  input  logic [C_NUM_SOURCES-1:0]                s_axis_tvalid,
  output logic [C_NUM_SOURCES-1:0]                s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0]                 m_axis_tdata,
  output logic                                    m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                   m_axis_tid,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_FORWARD
  } state_t;

  state_t                  state;
  logic [C_ID_WIDTH-1:0]   last_grant;
  logic [C_ID_WIDTH-1:0]   winner;
  logic [C_ID_WIDTH-1:0]   cand;
  logic                    found;
  logic                    fwd;
  logic                    pkt_done;
  logic [C_AXIS_WIDTH-1:0] src_data [C_NUM_SOURCES];
  logic [CNT_W-1:0]        cnt      [C_NUM_SOURCES];

  // Unpack the flattened input data and pack the counters for software.
  for (genvar g = 0; g < C_NUM_SOURCES; g++) begin : g_src
    assign src_data[g]                 = s_axis_tdata[g*C_AXIS_WIDTH +: C_AXIS_WIDTH];
    assign pkt_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Round-robin search: first valid source strictly after the previous winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= C_NUM_SOURCES; k++) begin
      cand = C_ID_WIDTH'((32'(last_grant) + k) % C_NUM_SOURCES);
      if (!found && s_axis_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Pass-through is gated by rst_n so no beat is handshaken while reset is held.
  assign fwd           = (state == ST_FORWARD) && rst_n;
  assign busy          = (state == ST_FORWARD);
  assign m_axis_tvalid = fwd && s_axis_tvalid[grant_idx];
  assign m_axis_tlast  = fwd && s_axis_tlast[grant_idx];
  assign m_axis_tdata  = fwd ? src_data[grant_idx] : '0;
  assign m_axis_tid    = fwd ? grant_idx : '0;
  assign pkt_done      = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    s_axis_tready = '0;
    if (fwd) s_axis_tready[grant_idx] = m_axis_tready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= C_ID_WIDTH'(C_NUM_SOURCES - 1);
      for (int i = 0; i < int'(C_NUM_SOURCES); i++) cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && found) begin
            grant_idx <= winner;
            state     <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (pkt_done) begin
            last_grant <= grant_idx;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A clear wins over a same-cycle completion; that packet goes uncounted.
      if (clear_counters) begin
        for (int i = 0; i < int'(C_NUM_SOURCES); i++) cnt[i] <= '0;
      end else if (pkt_done) begin
        cnt[grant_idx] <= cnt[grant_idx] + 32'd1;
      end
    end
  end

endmodule

// File: doc/circular_dma_stream_arbiter.md
Name: circular_dma_stream_arbiter

Overview:
Packet-level round-robin arbiter that merges C_NUM_SOURCES independent AXI-Stream message sources into the single S2MM data stream feeding the circular DMA FSM. A granted source keeps the output until its tlast beat, so messages are never interleaved in the ring buffer. The block also reports the active source via tid and keeps per-source message counters for software.

Parameters:
C_NUM_SOURCES, 4, number of input streams (2..16)
C_AXIS_WIDTH, 64, tdata width in bits, same on all inputs and the output
C_ID_WIDTH, $clog2(C_NUM_SOURCES), width of the grant index and m_axis_tid (minimum 1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  permits new grants; does not abort a packet in flight
clear_counters  in  1  single-cycle pulse, zeroes all pkt_count entries
busy  out  1  high while a packet is being forwarded
grant_idx  out  C_ID_WIDTH  index of the current or most recent granted source
pkt_count  out  32*C_NUM_SOURCES  per-source completed-packet counters, source i at bits [32i+31:32i]
s_axis_tdata  in  C_AXIS_WIDTH*C_NUM_SOURCES  flattened input data, source i at slice i
s_axis_tlast  in  C_NUM_SOURCES  per-source tlast
s_axis_tvalid  in  C_NUM_SOURCES  per-source tvalid
s_axis_tready  out  C_NUM_SOURCES  per-source tready
m_axis_tdata  out  C_AXIS_WIDTH  merged data to the DMA FSM
m_axis_tlast  out  1  end of message
m_axis_tid  out  C_ID_WIDTH  source index of the current beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  DMA FSM ready

Behaviour:
- Reset values: state ST_IDLE, grant_idx 0, last_grant C_NUM_SOURCES-1 (source 0 wins first), all pkt_count 0, busy 0. Outputs while reset is asserted: m_axis_tvalid 0, all s_axis_tready 0.
- States:
  - ST_IDLE: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, all s_axis_tready=0.
  - ST_FORWARD: combinational pass-through from source grant_idx: m_axis_tdata/tlast/tvalid = s_axis_*[grant_idx]; s_axis_tready[grant_idx] = m_axis_tready; all other treadies 0; m_axis_tid = grant_idx.
- ST_IDLE -> ST_FORWARD:
  - Condition: enable=1 and any s_axis_tvalid bit set.
  - Winner: first valid index searched upward from last_grant+1, wrapping modulo C_NUM_SOURCES. It is registered into grant_idx.
  - Timing: one bubble cycle per packet; the first data beat can transfer on the cycle after the grant is registered.
- ST_FORWARD -> ST_IDLE:
  - Condition: handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1.
  - Same edge: last_grant <= grant_idx, and pkt_count[grant_idx] increments, wrapping at 2^32.
- No timeout: a granted source that drops tvalid mid-packet holds the grant indefinitely.
- enable deasserted in ST_FORWARD: the current packet completes normally, then no new grant is issued. enable deasserted in ST_IDLE: no grant.
- Non-granted sources see tready=0 and must hold their data (AXIS rules); the arbiter never drops beats.
- grant_idx holds its value after the packet ends; busy = (state == ST_FORWARD).
- clear_counters takes priority over an increment in the same cycle: all counters are 0 on the next cycle and that packet is not counted.
- Single-beat packets (tvalid with tlast on the first beat) are legal: one beat, then return to ST_IDLE.
- Reset mid-packet: the block returns to ST_IDLE immediately and the partial packet is abandoned. Recovery of the downstream DMA is handled by resetting it together with this block.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,...,N-1,0. No source waits longer than N-1 packets.

Test Plan:
- Reset, then enable=1 with source 2 sending a 3-beat packet -> grant_idx=2 one cycle after valid; 3 beats appear on m_axis with tid=2 and tlast on beat 3; pkt_count[2]=1, others 0.
- All 4 sources continuously valid with 2-beat packets, 8 packets total -> grant order 0,1,2,3,0,1,2,3; no interleaving of beats; every pkt_count=2.
- m_axis_tready toggled 1/0 every cycle during a 4-beat packet from source 1 -> s_axis_tready[1] mirrors m_axis_tready; other treadies 0; data order preserved; exactly 4 handshakes.
- enable dropped on beat 2 of a 5-beat packet from source 0, with source 3 also valid -> all 5 beats complete; state ST_IDLE; source 3 is not granted until enable returns to 1.
- clear_counters pulsed on the same cycle as a tlast handshake from source 1, with pkt_count[1]=7 -> all counters read 0 on the next cycle.
- rst_n asserted mid-packet from source 2 -> next cycle busy=0, m_axis_tvalid=0, all treadies 0; after release, source 0 has priority.
